// File: rtl/bresenham_driver_pkg.sv
// Shared widths and FSM encoding for the polyline driver.
// No ports; imported by bresenham_driver.
package bresenham_driver_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int GUARD_DEF   = 1;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_NEXTV  = 3'd1;
  localparam logic [ST_W-1:0] S_LOAD   = 3'd2;
  localparam logic [ST_W-1:0] S_GUARD  = 3'd3;
  localparam logic [ST_W-1:0] S_WAIT   = 3'd4;
  localparam logic [ST_W-1:0] S_STREAM = 3'd5;
  localparam logic [ST_W-1:0] S_END    = 3'd6;

endpackage

// File: rtl/bresenham_driver.sv
// Polyline driver: feeds vertex pairs to the bresenham
// interpolator and merges its points into one stream.
// Ports: vtx_* vertex input (valid/ready, last flag);
//   i_* interpolator load/next/finished side;
//   pt_* point output (valid/ready, last flag);
//   seg_err dropped-segment pulse; busy = not idle.
module bresenham_driver #(
  parameter int          COORD_W = bresenham_driver_pkg::COORD_W_DEF,
  parameter int unsigned GUARD   = bresenham_driver_pkg::GUARD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vtx_valid,
  output logic               vtx_ready,
  input  logic [COORD_W-1:0] vtx_x,
  input  logic [COORD_W-1:0] vtx_y,
  input  logic               vtx_last,
  output logic [COORD_W-1:0] i_x1,
  output logic [COORD_W-1:0] i_y1,
  output logic [COORD_W-1:0] i_x2,
  output logic [COORD_W-1:0] i_y2,
  output logic               i_load,
  input  logic               i_ready,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               i_next,
  input  logic               i_finished,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  output logic               pt_last,
  output logic               seg_err,
  output logic               busy
);

  import bresenham_driver_pkg::*;

  localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GCW-1:0] G_LAST =
    GCW'((GUARD > 0) ? GUARD - 1 : 0);

  logic [ST_W-1:0]    state;
  logic [COORD_W-1:0] prev_x;
  logic [COORD_W-1:0] prev_y;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               lastseg;
  logic [GCW-1:0]     guard_cnt;

  logic st_idle;
  logic st_nextv;
  logic st_stream;
  logic st_end;
  logic vtx_acc;
  logic x_inc;

  assign st_idle   = (state == S_IDLE);
  assign st_nextv  = (state == S_NEXTV);
  assign st_stream = (state == S_STREAM);
  assign st_end    = (state == S_END);

  assign vtx_ready = st_idle | st_nextv;
  assign vtx_acc   = vtx_valid & vtx_ready;
  assign x_inc     = (vtx_x > prev_x);
  assign busy      = ~st_idle;
  assign i_load    = (state == S_LOAD);

  // Segment endpoint is withheld in STREAM; it is
  // the next segment's start or the END point.
  assign i_next = st_stream & ~i_finished & pt_ready;

  always_comb begin
    pt_valid = 1'b0;
    pt_last  = 1'b0;
    pt_x     = '0;
    pt_y     = '0;
    unique case (1'b1)
      st_stream: begin
        pt_valid = ~i_finished;
        pt_x     = i_x;
        pt_y     = i_y;
      end
      st_end: begin
        pt_valid = 1'b1;
        pt_last  = 1'b1;
        pt_x     = prev_x;
        pt_y     = prev_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prev_x    <= '0;
      prev_y    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      lastseg   <= 1'b0;
      guard_cnt <= '0;
      i_x1      <= '0;
      i_y1      <= '0;
      i_x2      <= '0;
      i_y2      <= '0;
      seg_err   <= 1'b0;
    end else begin
      seg_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (vtx_acc) begin
            prev_x <= vtx_x;
            prev_y <= vtx_y;
            state  <= vtx_last ? S_END : S_NEXTV;
          end
        end
        S_NEXTV: begin
          if (vtx_acc) begin
            cur_x   <= vtx_x;
            cur_y   <= vtx_y;
            lastseg <= vtx_last;
            if (x_inc) begin
              i_x1  <= prev_x;
              i_y1  <= prev_y;
              i_x2  <= vtx_x;
              i_y2  <= vtx_y;
              state <= S_LOAD;
            end else begin
              // Drop the segment; the new vertex
              // becomes the start of the next one.
              seg_err <= 1'b1;
              prev_x  <= vtx_x;
              prev_y  <= vtx_y;
              if (vtx_last) state <= S_END;
            end
          end
        end
        S_LOAD: begin
          guard_cnt <= '0;
          state     <= (GUARD == 0) ? S_WAIT : S_GUARD;
        end
        S_GUARD: begin
          // i_ready still shows the previous
          // segment's done flag here.
          if (guard_cnt == G_LAST) begin
            state <= S_WAIT;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_ready) state <= S_STREAM;
        end
        S_STREAM: begin
          if (i_finished) begin
            prev_x <= cur_x;
            prev_y <= cur_y;
            state  <= lastseg ? S_END : S_NEXTV;
          end
        end
        S_END: begin
          if (pt_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_driver.sv
// Bench for bresenham_driver with a behavioural
// interpolator peer and a polyline reference model.
module tb_bresenham_driver;

  localparam int CW      = 11;
  localparam int DIV_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vtx_valid;
  logic          vtx_ready;
  logic [CW-1:0] vtx_x;
  logic [CW-1:0] vtx_y;
  logic          vtx_last;
  logic [CW-1:0] i_x1;
  logic [CW-1:0] i_y1;
  logic [CW-1:0] i_x2;
  logic [CW-1:0] i_y2;
  logic          i_load;
  logic          i_ready;
  logic [CW-1:0] i_x;
  logic [CW-1:0] i_y;
  logic          i_next;
  logic          i_finished;
  logic          pt_valid;
  logic          pt_ready;
  logic [CW-1:0] pt_x;
  logic [CW-1:0] pt_y;
  logic          pt_last;
  logic          seg_err;
  logic          busy;

  always #5 clk = ~clk;

  bresenham_driver #(.COORD_W(CW), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_last(vtx_last),
    .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2),
    .i_load(i_load), .i_ready(i_ready),
    .i_x(i_x), .i_y(i_y), .i_next(i_next),
    .i_finished(i_finished),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
    .seg_err(seg_err), .busy(busy)
  );

  // Line y at column x, rounded half up (floor division).
  function automatic int line_y(input int x1, input int y1,
                                input int x2, input int y2,
                                input int x);
    int num;
    int den;
    int q;
    num = 2 * (x - x1) * (y2 - y1) + (x2 - x1);
    den = 2 * (x2 - x1);
    q = num / den;
    if (num < 0 && q * den != num) q = q - 1;
    return y1 + q;
  endfunction

  // Interpolator peer: done flag lags the load by a cycle.
  int            div_cnt;
  logic [CW-1:0] m_x1, m_y1, m_x2, m_y2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_x <= '0; i_y <= '0; i_ready <= 1'b1; div_cnt <= 0;
      m_x1 <= '0; m_y1 <= '0; m_x2 <= '0; m_y2 <= '0;
    end else begin
      i_ready <= (div_cnt == 0);
      if (i_load) begin
        m_x1 <= i_x1; m_y1 <= i_y1; m_x2 <= i_x2; m_y2 <= i_y2;
        i_x <= i_x1; i_y <= i_y1; div_cnt <= DIV_LAT;
      end else begin
        if (div_cnt > 0) div_cnt <= div_cnt - 1;
        if (i_next) begin
          i_x <= i_x + 1'b1;
          i_y <= CW'(line_y(int'(m_x1), int'(m_y1), int'(m_x2),
                            int'(m_y2), int'(i_x) + 1));
        end
      end
    end
  end
  assign i_finished = (i_x == m_x2);

  int n_next = 0;
  int n_load = 0;
  int n_seg  = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (i_next)  n_next <= n_next + 1;
      if (i_load)  n_load <= n_load + 1;
      if (seg_err) n_seg  <= n_seg + 1;
    end
  end

  typedef struct { int x; int y; bit last; } pv_t;

  pv_t vq[$];
  pv_t eq[$];
  int  ref_err;
  int  ref_loads;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  abort = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_v(input int x, input int y, input bit last);
    pv_t v;
    v.x = x; v.y = y; v.last = last;
    vq.push_back(v);
  endtask

  // Expected stream: each kept segment gives x1..x2-1,
  // then the final vertex alone carries last.
  task automatic build_ref();
    int  px, py;
    pv_t p;
    eq.delete(); ref_err = 0; ref_loads = 0;
    px = vq[0].x; py = vq[0].y;
    for (int i = 1; i < vq.size(); i++) begin
      if (vq[i].x > px) begin
        ref_loads++;
        for (int x = px; x < vq[i].x; x++) begin
          p.x = x; p.last = 1'b0;
          p.y = line_y(px, py, vq[i].x, vq[i].y, x);
          eq.push_back(p);
        end
      end else begin
        ref_err++;
      end
      px = vq[i].x; py = vq[i].y;
    end
    p.x = px; p.y = py; p.last = 1'b1;
    eq.push_back(p);
  endtask

  task automatic feed();
    int n;
    for (int i = 0; i < vq.size(); i++) begin
      if (abort) break;
      vtx_valid = 1'b1;
      vtx_x = CW'(vq[i].x); vtx_y = CW'(vq[i].y);
      vtx_last = vq[i].last;
      n = 0;
      while (!vtx_ready && !abort && n < 1000) begin
        @(negedge clk); n++;
      end
      if (!abort) chk("vtx_wait", 32'(n < 1000), 32'd1);
      @(negedge clk);
    end
    vtx_valid = 1'b0; vtx_last = 1'b0;
  endtask

  task automatic collect(input int stall, input int max_pts,
                         output int got);
    bit  stalled;
    bit  done;
    int  sx, sy, cyc;
    pv_t e;
    stalled = 0; done = 0; sx = 0; sy = 0; cyc = 0; got = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (stalled)
        chk("hold", 32'({pt_valid, pt_x, pt_y}),
            32'({1'b1, CW'(sx), CW'(sy)}));
      pt_ready = ($urandom_range(99) >= stall);
      if (pt_valid && pt_ready) begin
        stalled = 0; got++;
        if (eq.size() == 0) begin
          chk("extra_pt", 32'({pt_x, pt_y}), 32'hFFFF_FFFF);
        end else begin
          e = eq.pop_front();
          chk("point", 32'({pt_last, pt_x, pt_y}),
              32'({e.last, CW'(e.x), CW'(e.y)}));
        end
        if (!pt_last) chk("stream_vr", 32'({busy, vtx_ready}), 32'd2);
        if (pt_last || got == max_pts) done = 1;
      end else if (pt_valid) begin
        stalled = 1; sx = int'(pt_x); sy = int'(pt_y);
      end
    end
    chk("collect_done", 32'(done), 32'd1);
  endtask

  task automatic run_poly(input int stall);
    int n0, l0, s0, got;
    build_ref();
    n0 = n_next; l0 = n_load; s0 = n_seg;
    fork
      feed();
      collect(stall, 0, got);
    join
    pt_ready = 1'b1;
    @(negedge clk);
    chk("remaining", 32'(eq.size()), 32'd0);
    chk("n_next", 32'(n_next - n0), 32'(got - 1));
    chk("n_load", 32'(n_load - l0), 32'(ref_loads));
    chk("seg_err", 32'(n_seg - s0), 32'(ref_err));
    chk("idle", 32'({busy, pt_valid}), 32'd0);
  endtask

  int nv, x, got6;

  initial begin
    rst_n = 1'b0; vtx_valid = 1'b0; vtx_x = '0; vtx_y = '0;
    vtx_last = 1'b0; pt_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'({busy, pt_valid, pt_last, i_load, i_next,
                        seg_err}), 32'd0);
    chk("rst_p1", 32'({i_x1, i_y1}), 32'd0);
    chk("rst_p2", 32'({i_x2, i_y2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    vq.delete(); add_v(0, 0, 0); add_v(4, 2, 1);
    run_poly(0);

    vq.delete(); add_v(0, 0, 0); add_v(3, 3, 0); add_v(6, 0, 1);
    run_poly(0);

    vq.delete(); add_v(5, 7, 1);
    run_poly(0);

    vq.delete(); add_v(4, 4, 0); add_v(4, 9, 0); add_v(8, 9, 1);
    run_poly(0);

    vq.delete(); add_v(0, 0, 0); add_v(3, 3, 0); add_v(6, 0, 1);
    run_poly(40);

    vq.delete(); add_v(0, 0, 0); add_v(3, 3, 0); add_v(6, 0, 1);
    build_ref();
    abort = 0;
    fork
      feed();
      begin
        collect(0, 3, got6);
        @(negedge clk);
        chk("mid_busy", 32'({busy, vtx_ready}), 32'd2);
        abort = 1; rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({busy, pt_valid, i_next}), 32'd0);
        @(negedge clk);
        chk("rst_next", 32'({busy, pt_valid, i_next, pt_last}), 32'd0);
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1; abort = 0; eq.delete();
    @(negedge clk);
    vq.delete(); add_v(0, 0, 0); add_v(4, 2, 1);
    run_poly(0);

    for (int k = 0; k < 25; k++) begin
      vq.delete();
      nv = int'($urandom_range(1, 5));
      x = int'($urandom_range(0, 60));
      for (int j = 0; j < nv; j++) begin
        if (j > 0) begin
          if ($urandom_range(5) == 0) begin
            x = x - int'($urandom_range(0, 3));
            if (x < 0) x = 0;
          end else begin
            x = x + int'($urandom_range(1, 7));
          end
        end
        add_v(x, int'($urandom_range(0, 40)), j == nv - 1);
      end
      run_poly(int'($urandom_range(0, 50)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
